alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, operand and result width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_op  input  3*NREQ  per-requester op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 cmp. Requester i uses bits [3i+2:3i].
REQ-008 req_a, req_b  input  WIDTH*NREQ each  per-requester operands; requester i uses slice i.
REQ-009 alu_op  output  3  op to the shared combinational ALU.
REQ-010 alu_a, alu_b  output  WIDTH each  operands to the ALU.
REQ-011 alu_y  input  WIDTH  ALU result, combinational from alu_op/alu_a/alu_b.
REQ-012 resp_valid  output  1  response valid.
REQ-013 resp_ready  input  1  response consumer accept.
REQ-014 resp_id  output  clog2(NREQ)  index of the requester the response belongs to.
REQ-015 resp_data  output  WIDTH  registered ALU result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid is high, the block SHALL assert req_ready for the single winner that cycle, capture its op/a/b into internal registers and its index into resp_id, and go to EXEC; otherwise it SHALL stay in IDLE with req_ready all zero.
REQ-018 req_ready SHALL be combinational from req_valid and arbitration state, and SHALL be zero in EXEC and RESP.
REQ-019 EXEC: alu_op/alu_a/alu_b SHALL be driven from the captured registers; alu_y SHALL be captured into resp_data at the end of the EXEC cycle; the FSM SHALL then go to RESP.
REQ-020 Outside EXEC, alu_op/alu_a/alu_b SHALL hold their last values; they are not guaranteed stable for other users.
REQ-021 RESP: resp_valid SHALL be high; resp_id and resp_data SHALL stay stable until resp_valid&&resp_ready, after which the FSM SHALL go to IDLE on the next edge.
REQ-022 Latency SHALL be exactly 2 cycles from the accept edge to resp_valid high; minimum issue interval SHALL be 3 cycles.
REQ-023 Round-robin: a pointer ptr (0..NREQ-1) SHALL give priority to ptr, ptr+1, ... modulo NREQ; on grant to index g, ptr SHALL become (g+1) mod NREQ, wrapping NREQ-1 -> 0.
REQ-024 Requests arriving or dropping while in EXEC/RESP SHALL have no effect; arbitration samples req_valid only in IDLE.
REQ-025 A requester whose req_valid stays high SHALL be served within NREQ grants.

Reset
REQ-026 On reset the FSM SHALL go to IDLE, ptr to 0, resp_valid to 0, resp_id to 0, resp_data to 0, alu_op/alu_a/alu_b to 0, req_ready to 0.
REQ-027 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation; no response for it is ever issued.

Configuration
REQ-028 Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (lowest index wins) and ptr SHALL not exist; when undefined, round-robin per REQ-023 SHALL apply.

Verification
REQ-029 Single request: req 2 valid, op 000, a=0x05, b=0x03 -> req_ready[2] one cycle, resp_valid 2 cycles later, resp_id 2, resp_data 0x08.
REQ-030 All 4 valid continuously, resp_ready tied high -> grant order 0,1,2,3,0 (round-robin); with ALU_ARBITER_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 Backpressure: resp_ready low 5 cycles in RESP -> resp_valid/resp_id/resp_data stable 5 cycles, no new req_ready until after handshake.
REQ-032 Wrap: ptr=3 with req 3 and req 0 valid -> grant 3, then 0; ptr returns to 1.
REQ-033 Reset mid-EXEC with req 1 op 001 a=0x10 b=0x01 -> no resp_valid, ptr 0, next grant follows reset priority.
REQ-034 Requests toggling during EXEC/RESP -> ignored; only req_valid sampled in IDLE is granted.

Source files
------------

// File: rtl/alu_arbiter.sv
//----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU among NREQ requesters. A single
//   request is accepted at a time. It is executed for one cycle on the
//   shared ALU, and the result is held in a response register until the
//   consumer accepts it. Only then can the next request be accepted.
//
//   Sequence: IDLE (accept) -> EXEC (drive ALU, capture result) -> RESP
//   (present response, wait for handshake) -> IDLE.
//   From the accept edge to resp_valid the latency is 2 cycles. The
//   minimum issue interval is 3 cycles.
//
// Configuration:
//   ALU_ARBITER_FIXED_PRIO_EN
//     Defined:   fixed priority, lowest index wins; there is no pointer.
//     Undefined: round-robin arbitration with a rotating priority pointer.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  operand / result width
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   req_valid[NREQ]        per-requester request valid
//   req_ready[NREQ]        per-requester accept, at most one bit high
//   req_op[3*NREQ]         per-requester opcode, requester i at [3i+2:3i]
//   req_a/req_b            per-requester operands, requester i at slice i
//   alu_op/alu_a/alu_b     request to the shared combinational ALU
//   alu_y                  ALU result
//   resp_valid/resp_ready  response handshake
//   resp_id                index of the requester that owns the response
//   resp_data              registered ALU result
//----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [3*NREQ-1:0]          req_op,
  input  logic [WIDTH*NREQ-1:0]      req_a,
  input  logic [WIDTH*NREQ-1:0]      req_b,
  output logic [2:0]                 alu_op,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  input  logic [WIDTH-1:0]           alu_y,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic [WIDTH-1:0]           resp_data
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        r_alu_op;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic [ID_W-1:0]   r_resp_id;
  logic [WIDTH-1:0]  r_resp_data;

  logic              w_any_req;
  logic              w_accept;
  logic              w_capture;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [NREQ-1:0]   w_ready;
  logic [2:0]        w_sel_op;
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;

  //--------------------------------------------------------------------------
  // Arbitration
  //--------------------------------------------------------------------------
`ifdef ALU_ARBITER_FIXED_PRIO_EN

  // Lowest valid index wins. The scan runs high to low, so the last hit is
  // the lowest index.
  function automatic logic [ID_W-1:0] pick_fixed(input logic [NREQ-1:0] v);
    logic [ID_W-1:0] pick;
    logic [NREQ-1:0] sh;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sh = v >> k;
      if (sh[0]) begin
        pick = ID_W'(k);
      end
    end
    return pick;
  endfunction

  assign w_gnt_idx = pick_fixed(req_valid);

`else

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;

  // The scan starts at the pointer and walks upward modulo NREQ. The first
  // valid requester found wins. The index is folded back explicitly
  // because NREQ need not be a power of two.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NREQ-1:0] v,
                                              input logic [ID_W-1:0] p);
    logic [ID_W-1:0] pick;
    logic            found;
    logic [NREQ-1:0] sh;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      sh = v >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  assign w_gnt_idx = pick_rr(req_valid, r_ptr);

  // The pointer moves just past the winner, so the winner has the lowest
  // priority next time. A continuously requesting port is therefore
  // served within NREQ grants.
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0
                                                    : w_gnt_idx + ID_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
    end
  end

`endif

  assign w_any_req = |req_valid;

  // Operand selection for the current winner.
  always_comb begin
    w_sel_op = 3'(req_op >> (3 * int'(w_gnt_idx)));
    w_sel_a  = WIDTH'(req_a >> (WIDTH * int'(w_gnt_idx)));
    w_sel_b  = WIDTH'(req_b >> (WIDTH * int'(w_gnt_idx)));
  end

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state and strobes
  //--------------------------------------------------------------------------
  // Requests are sampled only in IDLE. While reset is asserted, the accept
  // is forced low so that req_ready stays zero even though the state
  // already reads IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req && !reset) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    end
  end

  //--------------------------------------------------------------------------
  // Capture at accept / result at end of EXEC
  //--------------------------------------------------------------------------
  // The captured request registers drive the ALU directly. They therefore
  // hold their last values outside EXEC, and they load at the accept edge,
  // so they are already valid for the whole EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_resp_id   <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_alu_op  <= w_sel_op;
        r_alu_a   <= w_sel_a;
        r_alu_b   <= w_sel_b;
        r_resp_id <= w_gnt_idx;
      end
      if (w_capture) begin
        r_resp_data <= alu_y;
      end
    end
  end

  assign req_ready  = w_ready;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
//----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter (NREQ=4, WIDTH=8) with directed vectors and models the
// shared ALU combinationally. The stimulus pushes the expected grant index
// and response (id, data) onto queues. A monitor compares them at every
// falling edge: grants on any req_ready, response contents on every
// resp_valid cycle, and the grant-to-resp_valid latency.
//----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [3*NREQ-1:0]      req_op;
  logic [WIDTH*NREQ-1:0]  req_a;
  logic [WIDTH*NREQ-1:0]  req_b;
  logic [2:0]             alu_op;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [WIDTH-1:0]       alu_y;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [1:0]             resp_id;
  logic [WIDTH-1:0]       resp_data;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model.
  always_comb begin
    case (alu_op)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      3'b101:  alu_y = alu_a << alu_b[2:0];
      3'b110:  alu_y = alu_a >> alu_b[2:0];
      default: alu_y = (alu_a < alu_b) ? 8'd1 : 8'd0;
    endcase
  end

  typedef struct {
    int id;
    int data;
  } resp_t;

  int    q_gnt[$];
  resp_t q_resp[$];
  int    checks = 0;
  int    errors = 0;

  task automatic fail(input string name, input int got, input int exp);
    errors++;
    $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) fail(name, got, exp);
  endtask

  task automatic exp_txn(input int id, input int data);
    resp_t r;
    r.id   = id;
    r.data = data;
    q_gnt.push_back(id);
    q_resp.push_back(r);
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3]     = op;
    req_a[WIDTH*i +: 8]  = a;
    req_b[WIDTH*i +: 8]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for n grants. It returns just after the accept edge of the last
  // one. When drop is set, the granted requester's valid is cleared right
  // after its accept edge.
  task automatic run_grants(input int n, input bit drop);
    int got;
    int guard;
    logic [NREQ-1:0] g;
    got   = 0;
    guard = 0;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (!reset && req_ready != '0) begin
        g = req_ready;
        got++;
        tick();
        if (drop) req_valid = req_valid & ~g;
      end
    end
    if (got < n) begin
      checks++;
      fail("grant_timeout", got, n);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q_resp.size() != 0 || q_gnt.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (q_resp.size() != 0 || q_gnt.size() != 0) begin
      checks++;
      fail("drain_timeout", q_resp.size() + q_gnt.size(), 0);
    end
    tick();
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  //--------------------------------------------------------------------------
  // Monitor
  //--------------------------------------------------------------------------
  int cyc     = 0;
  int gnt_cyc = 0;
  bit pend    = 1'b0;

  always @(negedge clk) begin
    int e;
    cyc++;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (req_ready != '0) begin
        checks++;
        if (q_gnt.size() == 0) begin
          fail("grant_unexpected", int'(req_ready), 0);
        end else begin
          e = q_gnt.pop_front();
          if (req_ready != (4'b0001 << e)) fail("grant", int'(req_ready), 1 << e);
        end
        gnt_cyc = cyc;
        pend    = 1'b1;
      end
      if (resp_valid) begin
        checks++;
        if (req_ready != '0) fail("ready_in_resp", int'(req_ready), 0);
        checks++;
        if (q_resp.size() == 0) begin
          fail("resp_unexpected", int'(resp_data), 0);
        end else begin
          if (int'(resp_id) != q_resp[0].id) fail("resp_id", int'(resp_id), q_resp[0].id);
          checks++;
          if (int'(resp_data) != q_resp[0].data)
            fail("resp_data", int'(resp_data), q_resp[0].data);
        end
        if (pend) begin
          checks++;
          if (cyc - gnt_cyc != 2) fail("latency", cyc - gnt_cyc, 2);
          pend = 1'b0;
        end
        if (resp_ready && q_resp.size() != 0) void'(q_resp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=0", q_resp.size());
    $fatal(1, "watchdog expired");
  end

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    req_valid  = '1;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset state, with every request asserted during reset.
    @(negedge clk);
    chk("rst_req_ready",  int'(req_ready),  0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_id",    int'(resp_id),    0);
    chk("rst_resp_data",  int'(resp_data),  0);
    chk("rst_alu_op",     int'(alu_op),     0);
    chk("rst_alu_a",      int'(alu_a),      0);
    chk("rst_alu_b",      int'(alu_b),      0);
    tick();
    req_valid = '0;
    reset     = 1'b0;
    tick();

    // Single request: requester 2, 0x05 + 0x03.
    set_req(2, 3'b000, 8'h05, 8'h03);
    exp_txn(2, 'h08);
    req_valid = 4'b0100;
    run_grants(1, 1'b1);
    drain();

    // All requesters held valid, starting from pointer 0.
    do_reset();
    set_req(0, 3'b000, 8'h10, 8'h20);
    set_req(1, 3'b001, 8'h10, 8'h01);
    set_req(2, 3'b010, 8'hF0, 8'h3C);
    set_req(3, 3'b100, 8'hAA, 8'hFF);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) exp_txn(0, 'h30);
`else
    exp_txn(0, 'h30);
    exp_txn(1, 'h0F);
    exp_txn(2, 'h30);
    exp_txn(3, 'h55);
    exp_txn(0, 'h30);
`endif
    req_valid = 4'b1111;
    run_grants(5, 1'b0);
    req_valid = '0;
    drain();

    // Backpressure: requester 2 shl. New requests raised in EXEC stay
    // pending until after the handshake.
    resp_ready = 1'b0;
    set_req(2, 3'b101, 8'h81, 8'h01);
    exp_txn(2, 'h02);
    req_valid = 4'b0100;
    run_grants(1, 1'b1);
    set_req(3, 3'b110, 8'h80, 8'h03);
    set_req(0, 3'b111, 8'h05, 8'h09);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    exp_txn(0, 'h01);
    exp_txn(3, 'h10);
`else
    exp_txn(3, 'h10);
    exp_txn(0, 'h01);
`endif
    req_valid = 4'b1001;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", int'(resp_valid), 1);
      tick();
    end
    resp_ready = 1'b1;
    run_grants(2, 1'b1);
    drain();

    // Pointer check after the wrap: requesters 0 and 1 both valid.
    set_req(0, 3'b000, 8'h01, 8'h01);
    set_req(1, 3'b010, 8'hF0, 8'h0F);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    exp_txn(0, 'h02);
    exp_txn(1, 'h00);
`else
    exp_txn(1, 'h00);
    exp_txn(0, 'h02);
`endif
    req_valid = 4'b0011;
    run_grants(2, 1'b1);
    drain();

    // Reset in the middle of EXEC abandons the operation.
    set_req(1, 3'b001, 8'h10, 8'h01);
    q_gnt.push_back(1);
    req_valid = 4'b0010;
    run_grants(1, 1'b1);
    #1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid", int'(resp_valid), 0);
    chk("abort_resp_data",  int'(resp_data),  0);
    chk("abort_resp_id",    int'(resp_id),    0);
    tick();
    // The pointer is back at 0, so requester 1 beats requester 3.
    set_req(3, 3'b110, 8'h80, 8'h03);
    exp_txn(1, 'h0F);
    exp_txn(3, 'h10);
    req_valid = 4'b1010;
    run_grants(2, 1'b1);
    drain();

    // Requests toggling during EXEC/RESP are ignored.
    set_req(0, 3'b100, 8'h3C, 8'h0F);
    exp_txn(0, 'h33);
    resp_ready = 1'b0;
    req_valid  = 4'b0001;
    run_grants(1, 1'b1);
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid  = '0;
    resp_ready = 1'b1;
    drain();
    repeat (3) tick();
    set_req(2, 3'b000, 8'hFF, 8'h02);
    exp_txn(2, 'h01);
    req_valid = 4'b0100;
    run_grants(1, 1'b1);
    drain();

    repeat (3) tick();
    chk("queues_empty", q_gnt.size() + q_resp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
